// File: rtl/freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : freq_meter                                                   |
// | Description : Measures the theremin antenna oscillator. The asynchronous   |
// |               square wave is synchronised into clk_100, and clk_100 cycles |
// |               are counted across PERIODS input periods. One period-sum     |
// |               word is published per window with a one-cycle valid strobe,  |
// |               and a no-signal flag reports a dead or missing antenna.      |
// |               Optional IIR averaging of the output is enabled by the       |
// |               FREQ_METER_AVG_EN macro.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module freq_meter #(
    parameter int          PERIODS   = 16,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] TIMEOUT   = 32'd1_000_000,
    parameter int          AVG_SHIFT = 3
) (
    input  logic             clk_100,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] meas_out,
    output logic             meas_valid,
    output logic             no_signal
);

    // Window state encoding
    localparam logic [0:0]       c_st_wait_first = 1'b0;
    localparam logic [0:0]       c_st_measure    = 1'b1;

    localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_timeout    = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] c_timeout_m1 = c_timeout - c_one;
    localparam logic [WIDTH-1:0] c_cyc_max    = {WIDTH{1'b1}};
    localparam logic [15:0]      c_periods_m1 = 16'(PERIODS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_cyc_cnt;
    logic [15:0]      r_edge_cnt;
    logic [WIDTH-1:0] r_idle_cnt;

    logic             w_edge;
    logic             w_in_measure;
    logic             w_idle_sat;
    logic             w_idle_expire;
    logic             w_cyc_wrap;
    logic             w_timeout;
    logic             w_close;

    // Rising edge of the synchronised input only
    assign w_edge        = r_sync2 & ~r_sync3;
    assign w_in_measure  = (r_state == c_st_measure);
    assign w_idle_sat    = (r_idle_cnt == c_timeout);
    // An edge arriving on the last idle cycle wins over the timeout
    assign w_idle_expire = ~w_edge & (r_idle_cnt == c_timeout_m1);
    // A window that would wrap the cycle counter is discarded like a timeout
    assign w_cyc_wrap    = w_in_measure & (r_cyc_cnt == c_cyc_max);
    assign w_timeout     = w_idle_expire | w_cyc_wrap;
    // Closing edge of a complete window
    assign w_close       = w_in_measure & w_edge & ~w_cyc_wrap
                           & (r_edge_cnt == c_periods_m1);

    // Two-flop synchroniser plus one delay flop for edge detection
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Window state register
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_wait_first;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: first edge opens measurement, timeout abandons it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_wait_first: begin
                if (w_edge) begin
                    w_state_next = c_st_measure;
                end
            end
            c_st_measure: begin
                if (w_timeout) begin
                    w_state_next = c_st_wait_first;
                end
            end
            default: begin
                w_state_next = c_st_wait_first;
            end
        endcase
    end

    // Idle counter: cleared by every edge, saturates at the timeout value
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (w_edge) begin
            r_idle_cnt <= '0;
        end else if (!w_idle_sat) begin
            r_idle_cnt <= r_idle_cnt + c_one;
        end
    end

    // Cycle and edge counters; the closing edge restarts the next window at once
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc_cnt  <= '0;
            r_edge_cnt <= '0;
        end else if (!w_in_measure) begin
            if (w_edge) begin
                r_cyc_cnt  <= '0;
                r_edge_cnt <= '0;
            end
        end else if (w_timeout || w_close) begin
            r_cyc_cnt  <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + c_one;
            if (w_edge) begin
                r_edge_cnt <= r_edge_cnt + 16'd1;
            end
        end
    end

`ifdef FREQ_METER_AVG_EN
    logic [WIDTH-1:0]    r_raw;
    logic                r_raw_valid;
    logic                r_avg_primed;
    logic signed [WIDTH:0] w_diff;
    logic signed [WIDTH:0] w_step;
    logic signed [WIDTH:0] w_sum;

    // avg + ((raw - avg) >>> AVG_SHIFT), one bit wider and signed
    assign w_diff = $signed({1'b0, r_raw}) - $signed({1'b0, meas_out});
    assign w_step = w_diff >>> AVG_SHIFT;
    assign w_sum  = $signed({1'b0, meas_out}) + w_step;

    // Capture the raw window count one cycle ahead of the filter
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_raw       <= '0;
            r_raw_valid <= 1'b0;
        end else begin
            r_raw_valid <= w_close;
            if (w_close) begin
                r_raw <= r_cyc_cnt + c_one;
            end
        end
    end

    // Filter update; the first window after reset or timeout loads directly
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            meas_out     <= '0;
            meas_valid   <= 1'b0;
            no_signal    <= 1'b0;
            r_avg_primed <= 1'b0;
        end else begin
            meas_valid <= r_raw_valid;
            if (r_raw_valid) begin
                if (r_avg_primed) begin
                    meas_out <= WIDTH'(w_sum);
                end else begin
                    meas_out <= r_raw;
                end
                r_avg_primed <= 1'b1;
            end else if (w_timeout) begin
                r_avg_primed <= 1'b0;
            end
            if (w_timeout) begin
                no_signal <= 1'b1;
            end else if (r_raw_valid) begin
                no_signal <= 1'b0;
            end
        end
    end
`else
    // Publish the raw window count; a valid result also clears no-signal
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            meas_out   <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= w_close;
            if (w_close) begin
                meas_out  <= r_cyc_cnt + c_one;
                no_signal <= 1'b0;
            end else if (w_timeout) begin
                no_signal <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
